btn_conditioner: RTL
====================

# btn_conditioner

Front-end conditioner for an active-low mechanical pushbutton. It synchronises the raw pin and debounces both edges with a counter-based Moore state machine. It emits single-cycle press, release, long-press and auto-repeat pulses. It sits directly between a board button pin and the counters and FSMs that consume button events, so those blocks see exactly one clean event per physical action.

## Interface
- DEBOUNCE_CYCLES, 480000: consecutive stable cycles required to accept a press or a release (40 ms at 12 MHz); legal range 1..2^24.
- LONG_CYCLES, 12000000: held cycles after an accepted press before long_press fires (1 s); legal range 1..2^24.
- REPEAT_CYCLES, 2400000: period of repeat_pulse once long_press has fired (200 ms); legal range 1..2^24.
- clk  in  1  system clock, 12 MHz.
- rst_btn  in  1  asynchronous, active-low reset. Low clears all state immediately.
- btn  in  1  raw pushbutton, active-low (0 = pressed), asynchronous to clk.
- btn_level  out  1  debounced level, 1 = pressed.
- press_pulse  out  1  one-cycle pulse on each accepted press.
- release_pulse  out  1  one-cycle pulse on each accepted release.
- long_press  out  1  one-cycle pulse when the button has been held LONG_CYCLES.
- repeat_pulse  out  1  one-cycle pulse every REPEAT_CYCLES after long_press while held.

## Operation
- Synchroniser: two flops on btn, both reset to 1 (released). pressed_s = ~sync2.
- One 24-bit counter cnt. It clears to 0 on every state change and on every event pulse. It never wraps, because each compare at PARAM-1 reloads it.
- Flag long_seen is set when long_press fires and cleared in IDLE.
- All outputs are registered. Reset value of all of them is 0.
- Every state below defines its response to the cases shown. In any other case the state increments cnt and stays.
- IDLE:
  - pressed_s=1: go to PRESS_WAIT.
- PRESS_WAIT:
  - pressed_s=0: return to IDLE. This is a bounce; no output.
  - pressed_s=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD, pulse press_pulse.
- HELD:
  - pressed_s=0: go to RELEASE_WAIT.
  - cnt==LONG_CYCLES-1: go to REPEAT, pulse long_press, set long_seen.
- REPEAT:
  - pressed_s=0: go to RELEASE_WAIT.
  - cnt==REPEAT_CYCLES-1: stay in REPEAT, pulse repeat_pulse.
- RELEASE_WAIT:
  - pressed_s=1: return to REPEAT if long_seen, else HELD. cnt restarts and no pulse is issued.
  - pressed_s=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE, pulse release_pulse.
- btn_level=1 exactly while the state is HELD, REPEAT or RELEASE_WAIT.
- Illegal state encodings return to IDLE on the next clock, with all outputs 0.
- The four pulses are mutually exclusive; at most one is high in any cycle.
- Each pulse is high for exactly one cycle.
- A press that does not survive debounce produces no output at all.
- A release bounce does not re-issue press_pulse. It does restart the HELD or REPEAT interval from 0.

## Timing
- Edge numbering: edge 0 is the first clk edge that samples btn=0, with btn stable afterwards.
  - sync2 goes low after edge 1.
  - IDLE→PRESS_WAIT at edge 2.
  - press_pulse and btn_level rise after edge 2+DEBOUNCE_CYCLES.
- long_press is high after edge 2+DEBOUNCE_CYCLES+LONG_CYCLES.
- repeat_pulse pulses follow long_press every REPEAT_CYCLES edges.
- Release path: count edge 0 as the first edge sampling btn=1, btn stable.
  - release_pulse is high, and btn_level falls, after edge 2+DEBOUNCE_CYCLES.
- DEBOUNCE_CYCLES=1 is legal. It gives one cycle in PRESS_WAIT and one cycle in RELEASE_WAIT.
- Asynchronous reset mid-operation:
  - All outputs drop to 0 immediately and state goes to IDLE.
  - No release_pulse is generated.
  - After rst_btn deasserts, a still-held button is re-qualified as a new press once DEBOUNCE_CYCLES stable cycles have passed.
- rst_btn deassertion is assumed synchronous to clk at system level. The block adds no reset synchroniser.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8.
- Reset: hold rst_btn=0 with btn=0 → all outputs 0. Release reset, btn stays 0 → press_pulse at edge 6 after reset release, btn_level=1.
- Clean press/release: btn 1→0 for 10 cycles, then 1 → exactly one press_pulse (edge 6), one release_pulse 6 edges after btn returns high, no long_press.
- Bounce rejection: btn toggles 0/1 every 2 cycles for 20 cycles, then rests at 1 → no pulses, btn_level stays 0.
- Long hold: btn=0 for 60 cycles → press_pulse at 6, long_press at 26, repeat_pulse at 34, 42, 50, 58. Then release → release_pulse 6 edges later.
- Release bounce in REPEAT: after long_press, btn high for 2 cycles then low → no release_pulse, no second press_pulse or long_press. Next repeat_pulse comes 8 edges after re-entering REPEAT.
- Reset mid-hold: assert rst_btn while btn_level=1 → outputs 0 on the same edge, no release_pulse. Deassert with btn=0 → new press_pulse 6 edges later.

Source files
------------

// File: rtl/btn_conditioner.sv
// Debounced front end for an active-low pushbutton: two-flop synchroniser,
// Moore debounce FSM, and single-cycle press/release/long/repeat event pulses.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int REPEAT_CYCLES   = 2400000
) (
  input  logic clk,
  input  logic rst_btn,
  input  logic btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_PRESS_WAIT   = 3'd1,
    S_HELD         = 3'd2,
    S_REPEAT       = 3'd3,
    S_RELEASE_WAIT = 3'd4
  } state_t;

  localparam logic [23:0] DEB_LAST  = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] LONG_LAST = 24'(LONG_CYCLES - 1);
  localparam logic [23:0] REP_LAST  = 24'(REPEAT_CYCLES - 1);

  logic        sync1_q, sync2_q;
  logic        pressed_s;
  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        long_seen_q, long_seen_d;
  logic        btn_level_q, btn_level_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;
  logic        repeat_q, repeat_d;

  // Both synchroniser stages reset to the released level so reset never
  // looks like a press edge.
  assign pressed_s = ~sync2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 24'd1;
    long_seen_d = long_seen_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The count is meaningless while idle; parking it at 0 keeps it from wrapping.
        cnt_d       = 24'd0;
        long_seen_d = 1'b0;
        if (pressed_s) begin
          state_d = S_PRESS_WAIT;
        end
      end

      S_PRESS_WAIT: begin
        if (!pressed_s) begin
          state_d = S_IDLE;
          cnt_d   = 24'd0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = S_HELD;
          press_d = 1'b1;
          cnt_d   = 24'd0;
        end
      end

      S_HELD: begin
        if (!pressed_s) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = 24'd0;
        end else if (cnt_q == LONG_LAST) begin
          state_d     = S_REPEAT;
          long_d      = 1'b1;
          long_seen_d = 1'b1;
          cnt_d       = 24'd0;
        end
      end

      S_REPEAT: begin
        if (!pressed_s) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = 24'd0;
        end else if (cnt_q == REP_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = 24'd0;
        end
      end

      S_RELEASE_WAIT: begin
        // A release bounce resumes the hold phase from a fresh interval.
        if (pressed_s) begin
          state_d = long_seen_q ? S_REPEAT : S_HELD;
          cnt_d   = 24'd0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
          cnt_d     = 24'd0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cnt_d       = 24'd0;
        long_seen_d = 1'b0;
      end
    endcase

    btn_level_d = (state_d == S_HELD) || (state_d == S_REPEAT) ||
                  (state_d == S_RELEASE_WAIT);
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= 24'd0;
      long_seen_q <= 1'b0;
      btn_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      sync1_q     <= btn;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_seen_q <= long_seen_d;
      btn_level_q <= btn_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  assign btn_level     = btn_level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule
